// File: rtl/multi_ctrl_fsm_if.sv
// Clock/reset bundle shared by the multicycle control unit and datapath.
interface ctrl_bus_if;
    logic clk;
    logic reset;
    modport central (input clk, input reset);
endinterface

// File: rtl/multi_ctrl_fsm.sv
// Multicycle MIPS control unit: Moore main FSM plus ALU function decoder.
module multi_ctrl_fsm #(
    parameter int N_STATE_BITS = 4
) (
    ctrl_bus_if.central             ctrl_bus,
    input  logic [31:0]             inst,
    input  logic                    zero,
    output logic                    i_or_d,
    output logic                    ireg_enab,
    output logic [1:0]              pc_src,
    output logic                    pc_enab,
    output logic                    mem_to_reg,
    output logic                    reg_dst,
    output logic                    reg_write,
    output logic                    alu_srcA,
    output logic [1:0]              alu_srcB,
    output logic [2:0]              alu_ctrl_sig,
    output logic                    mem_write,
    output logic                    illegal_op,
    output logic [N_STATE_BITS-1:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     r_state;
    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic       w_is_r;
    logic       w_is_lw;
    logic       w_is_sw;
    logic       w_is_beq;
    logic       w_is_addi;
    logic       w_is_j;
    logic       w_funct_ok;
    logic [2:0] w_alu_fn;
    logic       w_pc_write;
    logic       w_branch;
    logic       w_unused;

    assign w_op      = inst[31:26];
    assign w_funct   = inst[5:0];
    assign w_unused  = ^inst[25:6];
    assign w_is_r    = (w_op == OP_R);
    assign w_is_lw   = (w_op == OP_LW);
    assign w_is_sw   = (w_op == OP_SW);
    assign w_is_beq  = (w_op == OP_BEQ);
    assign w_is_addi = (w_op == OP_ADDI);
    assign w_is_j    = (w_op == OP_J);
    assign state     = N_STATE_BITS'(r_state);

    always_comb begin
        w_alu_fn   = ALU_ADD;
        w_funct_ok = 1'b1;
        unique case (w_funct)
            6'b100000: w_alu_fn = ALU_ADD;
            6'b100010: w_alu_fn = ALU_SUB;
            6'b100100: w_alu_fn = ALU_AND;
            6'b100101: w_alu_fn = ALU_OR;
            6'b101010: w_alu_fn = ALU_SLT;
            default:   w_funct_ok = 1'b0;
        endcase
    end

    always_ff @(posedge ctrl_bus.clk or posedge ctrl_bus.reset) begin
        if (ctrl_bus.reset) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: begin
                    unique case (1'b1)
                        (w_is_lw | w_is_sw):    r_state <= S_MEMADR;
                        (w_is_r & w_funct_ok):  r_state <= S_EXEC;
                        w_is_beq:               r_state <= S_BRANCH;
                        w_is_addi:              r_state <= S_ADDIEX;
                        w_is_j:                 r_state <= S_JUMP;
                        default:                r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR: r_state <= w_is_lw ? S_MEMRD : S_MEMWR;
                S_MEMRD:  r_state <= S_MEMWB;
                S_EXEC:   r_state <= S_ALUWB;
                S_ADDIEX: r_state <= S_ADDIWB;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        i_or_d       = 1'b0;
        ireg_enab    = 1'b0;
        pc_src       = 2'd0;
        mem_to_reg   = 1'b0;
        reg_dst      = 1'b0;
        reg_write    = 1'b0;
        alu_srcA     = 1'b0;
        alu_srcB     = 2'd0;
        alu_ctrl_sig = ALU_ADD;
        mem_write    = 1'b0;
        illegal_op   = 1'b0;
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        case (r_state)
            S_FETCH: begin
                ireg_enab  = 1'b1;
                alu_srcB   = 2'd1;
                w_pc_write = 1'b1;
            end
            S_DECODE: begin
                alu_srcB   = 2'd3;
                illegal_op = ~((w_is_r & w_funct_ok) | w_is_lw | w_is_sw
                             | w_is_beq | w_is_addi | w_is_j);
            end
            S_MEMADR, S_ADDIEX: begin
                alu_srcA = 1'b1;
                alu_srcB = 2'd2;
            end
            S_MEMRD: i_or_d = 1'b1;
            S_MEMWR: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_EXEC: begin
                alu_srcA     = 1'b1;
                alu_ctrl_sig = w_alu_fn;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_srcA     = 1'b1;
                alu_ctrl_sig = ALU_SUB;
                pc_src       = 2'd1;
                w_branch     = 1'b1;
            end
            S_JUMP: begin
                pc_src     = 2'd2;
                w_pc_write = 1'b1;
            end
            default: ;
        endcase
        pc_enab = w_pc_write | (w_branch & zero);
        // Reset must suppress every state-changing strobe, even in FETCH.
        if (ctrl_bus.reset) begin
            pc_enab    = 1'b0;
            ireg_enab  = 1'b0;
            reg_write  = 1'b0;
            mem_write  = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_ctrl_fsm.sv
// Directed table-driven bench for the multicycle control FSM.
module tb_multi_ctrl_fsm;

    ctrl_bus_if bus();

    logic [31:0] inst;
    logic        zero;
    logic        i_or_d, ireg_enab, pc_enab, mem_to_reg, reg_dst;
    logic        reg_write, alu_srcA, mem_write, illegal_op;
    logic [1:0]  pc_src, alu_srcB;
    logic [2:0]  alu_ctrl_sig;
    logic [3:0]  state;
    logic [15:0] w_o;

    int n_cmp = 0;
    int n_bad = 0;

    multi_ctrl_fsm #(.N_STATE_BITS(4)) dut (
        .ctrl_bus     (bus),
        .inst         (inst),
        .zero         (zero),
        .i_or_d       (i_or_d),
        .ireg_enab    (ireg_enab),
        .pc_src       (pc_src),
        .pc_enab      (pc_enab),
        .mem_to_reg   (mem_to_reg),
        .reg_dst      (reg_dst),
        .reg_write    (reg_write),
        .alu_srcA     (alu_srcA),
        .alu_srcB     (alu_srcB),
        .alu_ctrl_sig (alu_ctrl_sig),
        .mem_write    (mem_write),
        .illegal_op   (illegal_op),
        .state        (state)
    );

    assign w_o = {i_or_d, ireg_enab, pc_src, pc_enab, mem_to_reg, reg_dst,
                  reg_write, alu_srcA, alu_srcB, alu_ctrl_sig, mem_write,
                  illegal_op};

    initial bus.clk = 1'b0;
    always #5 bus.clk = ~bus.clk;

    function automatic logic [15:0] pk(
        input logic io, input logic ir, input logic [1:0] ps,
        input logic pe, input logic mr, input logic rd, input logic rw,
        input logic sa, input logic [1:0] sb, input logic [2:0] al,
        input logic mw, input logic il);
        return {io, ir, ps, pe, mr, rd, rw, sa, sb, al, mw, il};
    endfunction

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic        zero;
        logic [3:0]  st;
        logic [15:0] o;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string nm, input logic [3:0] es,
                       input logic [15:0] eo);
        n_cmp++;
        if (state !== es || w_o !== eo) begin
            n_bad++;
            $display("FAIL %s: state=%0d outs=%b, want state=%0d outs=%b",
                     nm, state, w_o, es, eo);
        end
    endtask

    logic [15:0] O_RST, O_F, O_D, O_ILL, O_MA, O_MR, O_MWR, O_MWB;
    logic [15:0] O_AWB, O_IWB, O_J, O_BR1, O_BR0;
    logic [15:0] O_EADD, O_ESUB, O_EAND, O_EOR, O_ESLT;

    localparam logic [31:0] I_LW   = 32'h8C410004;
    localparam logic [31:0] I_SW   = 32'hAC410004;
    localparam logic [31:0] I_ADD  = 32'h00430820;
    localparam logic [31:0] I_SUB  = 32'h00430822;
    localparam logic [31:0] I_AND  = 32'h00430824;
    localparam logic [31:0] I_OR   = 32'h00430825;
    localparam logic [31:0] I_SLT  = 32'h0043082A;
    localparam logic [31:0] I_ADDI = 32'h20410005;
    localparam logic [31:0] I_BEQ  = 32'h10220003;
    localparam logic [31:0] I_J    = 32'h08000010;
    localparam logic [31:0] I_BOP  = 32'hFC000000;
    localparam logic [31:0] I_BFN  = 32'h00430807;

    task automatic add_r(input string nm, input logic [31:0] ins,
                         input logic [15:0] ex);
        tv.push_back('{{nm, "_F"}, ins, 1'b0, 4'd0, O_F});
        tv.push_back('{{nm, "_D"}, ins, 1'b0, 4'd1, O_D});
        tv.push_back('{{nm, "_EX"}, ins, 1'b0, 4'd6, ex});
        tv.push_back('{{nm, "_WB"}, ins, 1'b0, 4'd7, O_AWB});
    endtask

    initial begin
        //            io ir ps  pe mr rd rw sa sb   alu    mw il
        O_RST  = pk(0, 0, 2'd0, 0, 0, 0, 0, 0, 2'd1, 3'b010, 0, 0);
        O_F    = pk(0, 1, 2'd0, 1, 0, 0, 0, 0, 2'd1, 3'b010, 0, 0);
        O_D    = pk(0, 0, 2'd0, 0, 0, 0, 0, 0, 2'd3, 3'b010, 0, 0);
        O_ILL  = pk(0, 0, 2'd0, 0, 0, 0, 0, 0, 2'd3, 3'b010, 0, 1);
        O_MA   = pk(0, 0, 2'd0, 0, 0, 0, 0, 1, 2'd2, 3'b010, 0, 0);
        O_MR   = pk(1, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 3'b010, 0, 0);
        O_MWR  = pk(1, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 3'b010, 1, 0);
        O_MWB  = pk(0, 0, 2'd0, 0, 1, 0, 1, 0, 2'd0, 3'b010, 0, 0);
        O_AWB  = pk(0, 0, 2'd0, 0, 0, 1, 1, 0, 2'd0, 3'b010, 0, 0);
        O_IWB  = pk(0, 0, 2'd0, 0, 0, 0, 1, 0, 2'd0, 3'b010, 0, 0);
        O_J    = pk(0, 0, 2'd2, 1, 0, 0, 0, 0, 2'd0, 3'b010, 0, 0);
        O_BR1  = pk(0, 0, 2'd1, 1, 0, 0, 0, 1, 2'd0, 3'b110, 0, 0);
        O_BR0  = pk(0, 0, 2'd1, 0, 0, 0, 0, 1, 2'd0, 3'b110, 0, 0);
        O_EADD = pk(0, 0, 2'd0, 0, 0, 0, 0, 1, 2'd0, 3'b010, 0, 0);
        O_ESUB = pk(0, 0, 2'd0, 0, 0, 0, 0, 1, 2'd0, 3'b110, 0, 0);
        O_EAND = pk(0, 0, 2'd0, 0, 0, 0, 0, 1, 2'd0, 3'b000, 0, 0);
        O_EOR  = pk(0, 0, 2'd0, 0, 0, 0, 0, 1, 2'd0, 3'b001, 0, 0);
        O_ESLT = pk(0, 0, 2'd0, 0, 0, 0, 0, 1, 2'd0, 3'b111, 0, 0);

        tv.push_back('{"lw_F",   I_LW, 1'b0, 4'd0, O_F});
        tv.push_back('{"lw_D",   I_LW, 1'b0, 4'd1, O_D});
        tv.push_back('{"lw_MA",  I_LW, 1'b0, 4'd2, O_MA});
        tv.push_back('{"lw_MR",  I_LW, 1'b0, 4'd3, O_MR});
        tv.push_back('{"lw_WB",  I_LW, 1'b0, 4'd4, O_MWB});
        tv.push_back('{"sw_F",   I_SW, 1'b0, 4'd0, O_F});
        tv.push_back('{"sw_D",   I_SW, 1'b0, 4'd1, O_D});
        tv.push_back('{"sw_MA",  I_SW, 1'b0, 4'd2, O_MA});
        tv.push_back('{"sw_MW",  I_SW, 1'b0, 4'd5, O_MWR});
        add_r("sub", I_SUB, O_ESUB);
        add_r("slt", I_SLT, O_ESLT);
        add_r("add", I_ADD, O_EADD);
        add_r("and", I_AND, O_EAND);
        add_r("or",  I_OR,  O_EOR);
        tv.push_back('{"addi_F",  I_ADDI, 1'b0, 4'd0,  O_F});
        tv.push_back('{"addi_D",  I_ADDI, 1'b0, 4'd1,  O_D});
        tv.push_back('{"addi_EX", I_ADDI, 1'b0, 4'd9,  O_MA});
        tv.push_back('{"addi_WB", I_ADDI, 1'b0, 4'd10, O_IWB});
        tv.push_back('{"beq1_F",  I_BEQ, 1'b1, 4'd0, O_F});
        tv.push_back('{"beq1_D",  I_BEQ, 1'b1, 4'd1, O_D});
        tv.push_back('{"beq1_BR", I_BEQ, 1'b1, 4'd8, O_BR1});
        tv.push_back('{"beq0_F",  I_BEQ, 1'b0, 4'd0, O_F});
        tv.push_back('{"beq0_D",  I_BEQ, 1'b1, 4'd1, O_D});
        tv.push_back('{"beq0_BR", I_BEQ, 1'b0, 4'd8, O_BR0});
        tv.push_back('{"j_F",     I_J, 1'b0, 4'd0,  O_F});
        tv.push_back('{"j_D",     I_J, 1'b0, 4'd1,  O_D});
        tv.push_back('{"j_JMP",   I_J, 1'b0, 4'd11, O_J});
        tv.push_back('{"bop_F",   I_BOP, 1'b0, 4'd0, O_F});
        tv.push_back('{"bop_D",   I_BOP, 1'b0, 4'd1, O_ILL});
        tv.push_back('{"bfn_F",   I_BFN, 1'b0, 4'd0, O_F});
        tv.push_back('{"bfn_D",   I_BFN, 1'b0, 4'd1, O_ILL});
        tv.push_back('{"lw2_F",   I_LW, 1'b0, 4'd0, O_F});
        tv.push_back('{"lw2_D",   I_LW, 1'b0, 4'd1, O_D});
        tv.push_back('{"lw2_MA",  I_LW, 1'b0, 4'd2, O_MA});
        tv.push_back('{"lw2_MR",  I_LW, 1'b0, 4'd3, O_MR});

        bus.reset = 1'b1;
        inst = I_LW;
        zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge bus.clk);
            #1;
            chk("reset_hold", 4'd0, O_RST);
        end
        bus.reset = 1'b0;

        foreach (tv[i]) begin
            inst = tv[i].inst;
            zero = tv[i].zero;
            #3;
            chk(tv[i].name, tv[i].st, tv[i].o);
            if (i != tv.size() - 1) begin
                @(posedge bus.clk);
                #1;
            end
        end

        // Async reset in the middle of MEMRD, before the MEMWB edge.
        #1;
        bus.reset = 1'b1;
        #1;
        chk("rst_async", 4'd0, O_RST);
        @(posedge bus.clk);
        #1;
        chk("rst_no_wb", 4'd0, O_RST);
        bus.reset = 1'b0;
        #3;
        chk("rst_fetch", 4'd0, O_F);
        @(posedge bus.clk);
        #1;
        chk("rst_decode", 4'd1, O_D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
